fp32_div: RTL and testbench

//  Iterative IEEE-754 single-precision divider: out = in_a / in_b. Inverse of the FP32 multiply path.

---
 rtl/fp32_pkg.sv | 15 +
 rtl/fp32_div_if.sv | 17 +
 rtl/fp32_classify.sv | 20 ++
 rtl/fp32_div.sv | 139 +++++++++++++
 tb/tb_fp32_div.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 constants, flag bit positions and the iterative-unit state encoding.
// Used by both the divider and the multiplier.
package fp32_pkg;
  localparam int          FP32_BIAS    = 127;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [30:0] FP32_INF     = 31'h7F80_0000;
  localparam logic [30:0] FP32_QNAN    = 31'h7F80_0001;

  localparam int FLG_ZERO = 0;
  localparam int FLG_INF  = 1;
  localparam int FLG_NAN  = 2;
  localparam int FLG_DIVZ = 3;

  typedef enum logic [1:0] {IDLE, CALC, PACK, DONE} state_t;
endpackage

// File: rtl/fp32_div_if.sv
// Operand/result handshake bundle for the fp32 divider.
// The master side feeds operands and accepts results; the slave side is the divider.
interface fp32_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_data, out_flags);
  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_data, out_flags);
endinterface

// File: rtl/fp32_classify.sv
// Combinational fp32 operand decode with flush-to-zero of denormals.
// mant carries the hidden bit, so it is only meaningful for normal numbers.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] value,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] mant,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);
  assign sign    = value[31];
  assign exp     = value[30:23];
  assign mant    = {1'b1, value[22:0]};
  assign is_zero = (value[30:23] == 8'h00);
  assign is_inf  = (value[30:23] == FP32_EXP_MAX) && (value[22:0] == 23'h0);
  assign is_nan  = (value[30:23] == FP32_EXP_MAX) && (value[22:0] != 23'h0);
endmodule

// File: rtl/fp32_div.sv
// Iterative fp32 divider: one restoring quotient bit per cycle, truncated result, FTZ.
// Special operand pairs bypass the iteration and complete on the acceptance edge.
module fp32_div
  import fp32_pkg::*;
#(
  parameter logic [30:0] QNAN_BITS = FP32_QNAN,
  parameter int          ITER      = 24
) (
  input  logic       clk,
  input  logic       rstn,
  fp32_div_if.slave  bus
);
  state_t state, state_nxt;

  logic        a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [7:0]  a_exp, b_exp;
  logic [23:0] a_mant, b_mant;

  logic              s;
  logic signed [9:0] e;
  logic [23:0]       mb;
  logic [25:0]       r;
  // Leading quotient bit is always 1 and falls off the top, so only 23 bits are kept.
  logic [22:0]       q;
  logic [4:0]        cnt;
  logic [31:0]       data_q;
  logic [3:0]        flags_q;

  logic        special, adj, r_ge;
  logic [31:0] spec_data, pack_data;
  logic [3:0]  spec_flags, pack_flags;
  logic [9:0]  e_calc;
  logic [25:0] r_sub, r_next;

  fp32_classify u_cls_a (.value(bus.in_a), .sign(a_sign), .exp(a_exp), .mant(a_mant),
                         .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fp32_classify u_cls_b (.value(bus.in_b), .sign(b_sign), .exp(b_exp), .mant(b_mant),
                         .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  always_comb begin
    special    = 1'b1;
    spec_flags = 4'b0;
    spec_data  = {a_sign ^ b_sign, 31'h0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_data[30:0]     = QNAN_BITS;
      spec_flags[FLG_NAN] = 1'b1;
    end else if (b_zero && !a_zero && !a_inf) begin
      spec_data[30:0]      = FP32_INF;
      spec_flags[FLG_INF]  = 1'b1;
      spec_flags[FLG_DIVZ] = 1'b1;
    end else if (a_inf) begin
      spec_data[30:0]     = FP32_INF;
      spec_flags[FLG_INF] = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_flags[FLG_ZERO] = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  assign adj    = (a_mant < b_mant);
  assign e_calc = {2'b0, a_exp} - {2'b0, b_exp} + 10'(FP32_BIAS) - {9'b0, adj};

  // R stays below 2*mb, so the shifted difference never loses a significant bit.
  assign r_ge   = (r >= {2'b0, mb});
  assign r_sub  = r - {2'b0, mb};
  assign r_next = r_ge ? (r_sub << 1) : (r << 1);

  always_comb begin
    pack_flags = 4'b0;
    pack_data  = {s, e[7:0], q};
    if (e >= 10'sd255) begin
      pack_data           = {s, FP32_INF};
      pack_flags[FLG_INF] = 1'b1;
    end else if (e <= 10'sd0) begin
      pack_data            = {s, 31'h0};
      pack_flags[FLG_ZERO] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == 5'd0) state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s       <= 1'b0;
      e       <= '0;
      mb      <= '0;
      r       <= '0;
      q       <= '0;
      cnt     <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          s   <= a_sign ^ b_sign;
          e   <= e_calc;
          mb  <= b_mant;
          r   <= adj ? {1'b0, a_mant, 1'b0} : {2'b0, a_mant};
          q   <= '0;
          cnt <= 5'(ITER - 1);
          if (special) begin
            data_q  <= spec_data;
            flags_q <= spec_flags;
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= {q[21:0], r_ge};
          cnt <= cnt - 5'd1;
        end
        PACK: begin
          data_q  <= pack_data;
          flags_q <= pack_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_flags = flags_q;
endmodule

// File: tb/tb_fp32_div.sv
// Directed bench for fp32_div: vector table for results/flags/latency, plus
// backpressure and mid-operation reset sequences.
module tb_fp32_div;
  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  fp32_div_if bus ();

  fp32_div dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Presents operands and returns #1 after the acceptance edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from the acceptance edge (edge 1) until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 26};
    vecs[2]  = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 4'b0000, 26};
    vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26};
    vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1010, 1};
    vecs[5]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1010, 1};
    vecs[6]  = '{32'h00000000, 32'h00000000, 32'h7F800001, 4'b0100, 1};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 32'h7F800001, 4'b0100, 1};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7F800001, 4'b0100, 1};
    vecs[9]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0001, 1};
    vecs[10] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0001, 1};
    vecs[11] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 26};
    vecs[12] = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 26};

    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_data",  bus.out_data,           32'h0);
    chk("rst_out_flags", {28'h0, bus.out_flags}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(lat);
      chk($sformatf("v%0d_lat", i),   lat,                    vecs[i].lat);
      chk($sformatf("v%0d_data", i),  bus.out_data,           vecs[i].data);
      chk($sformatf("v%0d_flags", i), {28'h0, bus.out_flags}, {28'h0, vecs[i].flags});
      pop();
    end

    // Backpressure: result held, second request waits until the handshake completes.
    start_op(32'h40C00000, 32'h40000000);
    wait_result(lat);
    chk("bp_lat", lat, 26);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h3F800000;
    bus.in_b     = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("bp_hold_data",  bus.out_data,           32'h40400000);
      chk("bp_hold_ready", {31'h0, bus.in_ready},  32'h0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_idle_ready", {31'h0, bus.in_ready},  32'h1);
    chk("bp_idle_valid", {31'h0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_taken", {31'h0, bus.in_ready}, 32'h0);
    wait_result(lat);
    chk("bp2_lat",  lat,          26);
    chk("bp2_data", bus.out_data, 32'h3EAAAAAA);
    pop();

    // Reset while CALC has cnt==10 (13 iteration edges after acceptance).
    start_op(32'h40C00000, 32'h40000000);
    repeat (13) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
    chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("mid_rst_out_data",  bus.out_data,           32'h0);
    chk("mid_rst_out_flags", {28'h0, bus.out_flags}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_valid", {31'h0, bus.out_valid}, 32'h0);
    end
    chk("post_rst_ready", {31'h0, bus.in_ready}, 32'h1);
    start_op(32'h40C00000, 32'h40000000);
    wait_result(lat);
    chk("post_rst_lat",   lat,                    26);
    chk("post_rst_data",  bus.out_data,           32'h40400000);
    chk("post_rst_flags", {28'h0, bus.out_flags}, 32'h0);
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
